// File: rtl/rom_io_bridge.sv
// Program-memory fetch and single 4-bit I/O port companion for the 4-bit CPU nibble bus.
// Tracks the 8-phase cycle from sync, returns opcode nibbles, and snoops SRC/WRR/RDR.
module rom_io_bridge #(
   parameter logic [3:0] CHIP_ID = 4'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt,
   input  logic        sync,
   input  logic        rom_cmd,
   input  logic [3:0]  data_i,
   output logic [3:0]  data_o,
   output logic        data_en,
   output logic [11:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic [3:0]  port_i,
   output logic [3:0]  port_o
);

   typedef enum logic [3:0] {
      UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3
   } phase_t;

   typedef enum logic [1:0] {
      XOP_NONE, XOP_SRC, XOP_WRR, XOP_RDR
   } xop_t;

   phase_t      phase_q;
   xop_t        xop_q;
   logic [7:0]  addr_lo_q;
   logic [11:0] mem_addr_q;
   logic [7:0]  opbyte_q;
   logic        skip_q;
   logic [3:0]  src_chip_q;
   logic [3:0]  port_q;

   logic [3:0]  opr, opa;
   logic        two_byte_d;
   xop_t        xop_d;

   assign opr = opbyte_q[7:4];
   assign opa = opbyte_q[3:0];

   // Opcodes whose second byte arrives in the following instruction cycle
   always_comb begin
      two_byte_d = 1'b0;
      case (opr)
         4'h1, 4'h4, 4'h5, 4'h7: two_byte_d = 1'b1;
         4'h2, 4'h3:             two_byte_d = ~opa[0];
         default:                two_byte_d = 1'b0;
      endcase
   end

   always_comb begin
      xop_d = XOP_NONE;
      if (opr == 4'h2 && opa[0])   xop_d = XOP_SRC;
      else if (opbyte_q == 8'hE2)  xop_d = XOP_WRR;
      else if (opbyte_q == 8'hEA)  xop_d = XOP_RDR;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         phase_q    <= UNSYNC;
         xop_q      <= XOP_NONE;
         addr_lo_q  <= '0;
         mem_addr_q <= '0;
         opbyte_q   <= '0;
         skip_q     <= 1'b0;
         src_chip_q <= '0;
         port_q     <= '0;
      end else if (!halt) begin
         if (sync) begin
            phase_q <= A1;
         end else begin
            case (phase_q)
               UNSYNC:  phase_q <= UNSYNC;
               A1:      phase_q <= A2;
               A2:      phase_q <= A3;
               A3:      phase_q <= M1;
               M1:      phase_q <= M2;
               M2:      phase_q <= X1;
               X1:      phase_q <= X2;
               X2:      phase_q <= X3;
               X3:      phase_q <= A1;
               default: phase_q <= UNSYNC;
            endcase
         end

         case (phase_q)
            A1: addr_lo_q[3:0] <= data_i;
            A2: addr_lo_q[7:4] <= data_i;
            A3: mem_addr_q     <= {data_i, addr_lo_q};
            M1: opbyte_q       <= mem_data;
            M2: begin
               // The second byte of a two-byte opcode is fetched but never decoded
               if (skip_q) begin
                  skip_q <= 1'b0;
                  xop_q  <= XOP_NONE;
               end else begin
                  skip_q <= two_byte_d;
                  xop_q  <= xop_d;
               end
            end
            X2: begin
               if (xop_q == XOP_SRC && rom_cmd)
                  src_chip_q <= data_i;
               if (xop_q == XOP_WRR && src_chip_q == CHIP_ID)
                  port_q <= data_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      data_en = 1'b0;
      data_o  = 4'h0;
      case (phase_q)
         M1: begin
            data_en = 1'b1;
            data_o  = mem_data[7:4];
         end
         M2: begin
            data_en = 1'b1;
            data_o  = opbyte_q[3:0];
         end
         X2: begin
            if (xop_q == XOP_RDR && src_chip_q == CHIP_ID) begin
               data_en = 1'b1;
               data_o  = port_i;
            end
         end
         default: ;
      endcase
   end

   assign mem_addr = mem_addr_q;
   assign port_o   = port_q;

endmodule

// File: tb/tb_rom_io_bridge.sv
// Scoreboarded bench: instruction-level model predicts every bus drive (clock index and nibble)
// and the port latch; a negedge monitor pops and compares whenever data_en is seen.
module tb_rom_io_bridge;

   localparam logic [3:0] ID = 4'h3;

   logic        clock = 1'b0;
   logic        reset, halt, sync, rom_cmd;
   logic [3:0]  data_i, data_o, port_i, port_o;
   logic        data_en;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data;
   logic [7:0]  rom [0:4095];

   rom_io_bridge #(.CHIP_ID(ID)) dut (
      .clock(clock), .reset(reset), .halt(halt), .sync(sync), .rom_cmd(rom_cmd),
      .data_i(data_i), .data_o(data_o), .data_en(data_en), .mem_addr(mem_addr),
      .mem_data(mem_data), .port_i(port_i), .port_o(port_o)
   );

   assign mem_data = rom[mem_addr];

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [3:0] nib;
   } exp_t;
   exp_t q[$];

   int vectors = 0;
   int errors  = 0;
   bit mon_on  = 0;

   bit         m_skip;
   logic [3:0] m_src, m_port;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      sync    = 1'b0;
      halt    = 1'b0;
      rom_cmd = 1'($urandom);
      data_i  = 4'($urandom);
      port_i  = 4'($urandom);
   endtask

   task automatic expect_drive(input logic [3:0] nib);
      exp_t e;
      e.cyc = cyc;
      e.nib = nib;
      q.push_back(e);
   endtask

   function automatic bit is_two_byte(input logic [7:0] b);
      return (b[7:4] == 4'h1) || (b[7:4] == 4'h4) || (b[7:4] == 4'h5) || (b[7:4] == 4'h7) ||
             ((b[7:4] == 4'h2 || b[7:4] == 4'h3) && !b[0]);
   endfunction

   // One instruction cycle A1..X3; X3 carries sync for the next cycle.
   task automatic inst(input logic [11:0] a, input logic [3:0] xd, input bit rc,
                       input logic [3:0] pin, input int hold_m1, input bit rst_m2);
      logic [7:0] b;
      bit live;
      b = rom[a];
      live = !m_skip;
      idle(); data_i = a[3:0];  step();
      idle(); data_i = a[7:4];  step();
      idle(); data_i = a[11:8]; step();
      for (int i = 0; i <= hold_m1; i++) begin
         idle();
         halt = (i < hold_m1);
         check("mem_addr", mem_addr, a);
         expect_drive(b[7:4]);
         step();
      end
      idle();
      expect_drive(b[3:0]);
      if (rst_m2) begin
         reset = 1'b0;
         step();
         idle();
         m_skip = 0; m_src = 4'h0; m_port = 4'h0;
         check("port_o_after_reset", port_o, 4'h0);
         check("data_en_after_reset", data_en, 1'b0);
         step();
         reset = 1'b1;
         return;
      end
      step();
      idle(); step();
      idle(); data_i = xd; rom_cmd = rc; port_i = pin;
      if (live) begin
         if (b[7:4] == 4'h2 && b[0] && rc) m_src = xd;
         else if (b == 8'hE2 && m_src == ID) m_port = xd;
         else if (b == 8'hEA && m_src == ID) expect_drive(pin);
      end
      step();
      m_skip = live ? is_two_byte(b) : 1'b0;
      idle(); sync = 1'b1;
      check("port_o", port_o, m_port);
      step();
   endtask

   // Start a cycle, then re-sync from A2: the next clock must be A1 again.
   task automatic abort_a2();
      idle(); step();
      idle(); sync = 1'b1; step();
   endtask

   always @(negedge clock) begin
      if (mon_on) begin
         if (data_en === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_drive: got %0h expected none (cyc %0d)", data_o, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.cyc != cyc || e.nib !== data_o) begin
                  errors++;
                  $display("FAIL bus_drive: got %0h at cyc %0d expected %0h at cyc %0d",
                           data_o, cyc, e.nib, e.cyc);
               end
            end
         end else begin
            vectors++;
            if (data_en !== 1'b0 || data_o !== 4'h0) begin
               errors++;
               $display("FAIL idle_bus: got en %b data %0h expected en 0 data 0 (cyc %0d)",
                        data_en, data_o, cyc);
            end
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               exp_t e;
               e = q.pop_front();
               vectors++;
               errors++;
               $display("FAIL missing_drive: got none expected %0h at cyc %0d", e.nib, e.cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [7:0] kinds [10];
      kinds = '{8'h21, 8'hE2, 8'hEA, 8'h40, 8'h12, 8'h50, 8'h20, 8'h31, 8'h72, 8'hA5};
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      m_skip = 0; m_src = 4'h0; m_port = 4'h0;
      reset = 1'b0;
      idle();
      step(); step();
      check("reset_data_en", data_en, 1'b0);
      check("reset_data_o", data_o, 4'h0);
      check("reset_mem_addr", mem_addr, 12'h000);
      check("reset_port_o", port_o, 4'h0);
      reset = 1'b1;
      mon_on = 1;
      idle(); step();
      idle(); sync = 1'b1; step();

      rom[12'h123] = 8'hA5;
      inst(12'h123, 4'h0, 0, 4'h0, 0, 0);
      rom[12'h200] = 8'h21;
      rom[12'h201] = 8'hE2;
      rom[12'h202] = 8'hEA;
      rom[12'h300] = 8'h40;
      inst(12'h200, ID,   1, 4'h0, 0, 0);
      inst(12'h201, 4'h9, 0, 4'h0, 0, 0);
      check("wrr_port", port_o, 4'h9);
      inst(12'h200, 4'h4, 1, 4'h0, 0, 0);
      inst(12'h201, 4'h5, 0, 4'h0, 0, 0);
      check("wrr_other_chip", port_o, 4'h9);
      inst(12'h200, ID,   1, 4'h0, 0, 0);
      inst(12'h202, 4'h0, 0, 4'h6, 0, 0);
      inst(12'h300, 4'h0, 0, 4'h0, 0, 0);
      inst(12'h201, 4'hF, 0, 4'h0, 0, 0);
      check("skip_wrr", port_o, 4'h9);
      inst(12'h201, 4'hC, 0, 4'h0, 0, 0);
      check("wrr_after_skip", port_o, 4'hC);
      inst(12'h123, 4'h0, 0, 4'h0, 3, 0);
      abort_a2();
      inst(12'h202, 4'h0, 0, 4'hB, 0, 0);
      inst(12'h123, 4'h0, 0, 4'h0, 0, 1);
      for (int i = 0; i < 6; i++) begin idle(); step(); end
      idle(); sync = 1'b1; step();
      inst(12'h201, 4'h7, 0, 4'h0, 0, 0);
      check("wrr_after_reset_unselected", port_o, 4'h0);

      for (int n = 0; n < 80; n++) begin
         logic [11:0] a;
         logic [3:0]  xd;
         int          hold;
         a = 12'($urandom_range(0, 4095));
         rom[a] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : kinds[$urandom_range(0, 9)];
         xd = ($urandom_range(0, 1) == 1) ? ID : 4'($urandom);
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         if ($urandom_range(0, 9) == 0) abort_a2();
         inst(a, xd, 1'($urandom), 4'($urandom), hold, 0);
      end

      idle(); step(); step();
      mon_on = 0;
      check("scoreboard_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rom_io_bridge.md
# rom_io_bridge

Program-memory and I/O-port companion to the 4-bit CPU core, sitting directly on the CPU's shared nibble bus. It follows the 8-phase instruction cycle from `sync`, collects the 12-bit fetch address from the CPU's address nibbles, and returns the opcode byte from an asynchronous-read program memory. It also snoops fetched opcodes to implement one 4001-style 4-bit I/O port: SRC selects the port, WRR writes it, RDR reads it.

## Interface
- `CHIP_ID`, default 4'h0: chip number this port answers to on SRC.
- `clock` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `halt` input 1: when high, all internal state holds; outputs keep their current value.
- `sync` input 1: CPU cycle marker, high during the X3 phase.
- `rom_cmd` input 1: CPU ROM command strobe, asserted in A3 and in X2 of SRC.
- `data_i` input 4: CPU bus output, meaning address nibbles, SRC chip nibble, or accumulator.
- `data_o` output 4: nibble driven toward the CPU.
- `data_en` output 1: `data_o` is valid and owns the bus.
- `mem_addr` output 12: program-memory address, registered.
- `mem_data` input 8: program-memory byte, combinational read of `mem_addr`.
- `port_i` input 4: external input pins, read by RDR.
- `port_o` output 4: external output latch, written by WRR.

## Operation
- Phase register states: UNSYNC, A1, A2, A3, M1, M2, X1, X2, X3. Reset value is UNSYNC.
- From any state, a sampled `sync`=1 moves the next phase to A1. This also resyncs if `sync` arrives off-schedule.
- Otherwise phases advance A1→A2→…→X3→A1.
- UNSYNC stays in UNSYNC until `sync` is seen. Nothing is driven while in UNSYNC.
- Address capture:
  - end of A1: `data_i` → addr[3:0]
  - end of A2: `data_i` → addr[7:4]
  - end of A3: `data_i` → addr[11:8], and `{data_i, addr[7:0]}` → `mem_addr`
- `rom_cmd` is not required for the fetch, since memory is a flat 4K.
- Fetch drive:
  - M1: `data_o` = `mem_data[7:4]`, `data_en`=1.
  - End of M1: `mem_data` is latched into `opbyte`.
  - M2: `data_o` = `opbyte[3:0]`, `data_en`=1.
- Decode happens at end of M2 on `opbyte`, unless `skip`=1.
- Two-byte opcodes set `skip` for the next instruction cycle: OPR 1 (JCN), 2 with OPA even (FIM), 3 with OPA even (FIN), 4 (JUN), 5 (JMS), 7 (ISZ).
- `skip` is cleared at the end of the following M2. The fetched second byte is still driven on the bus but never decoded.
- SRC (OPR 2, OPA odd): at end of X2, if `rom_cmd`=1, `data_i` → `src_chip`.
- WRR (byte E2): at end of X2, if `src_chip`==`CHIP_ID`, `data_i` → `port_o`.
- RDR (byte EA): during X2, if `src_chip`==`CHIP_ID`, `data_o` = `port_i` and `data_en`=1. Otherwise nothing is driven.
- All other opcodes: no action, and `data_en`=0 in X phases.
- Reset values: phase UNSYNC, `mem_addr` 0, `opbyte` 0, `skip` 0, `src_chip` 0, `port_o` 0, `data_en` 0, `data_o` 0.
- `data_o` is 0 whenever `data_en`=0.
- Reset applied mid-cycle returns to UNSYNC immediately. The next fetch waits for `sync`.
- `halt`=1: phase, address, `opbyte`, `skip`, `src_chip` and `port_o` hold. `data_en`/`data_o` continue to reflect the held phase.
- Reset overrides `halt`.

## Timing
- `data_en`/`data_o` are combinational from registered phase/state plus `mem_data`/`port_i`. There are no extra pipeline stages.
- Fetch latency: `mem_addr` updates on the edge ending A3 and is valid for all of M1. The opcode high nibble appears in the same M1 clock.
- The CPU samples the bus on the edge ending M1/M2/X2. This block never drives in A1–A3, X1 or X3.
- `port_o` updates on the edge ending X2 of WRR and is visible from X3.
- SRC and WRR/RDR must be separate instruction cycles; the selection persists until the next SRC.
- Back-to-back cycles: X3 with `sync` → A1 with no idle clock.

## Test plan
- Reset low 2 clocks, then pulse `sync`; drive address nibbles 3,2,1 in A1–A3; `mem_data`=f(`mem_addr`) with 0x123→0xA5 -> `mem_addr`=0x123; bus 0xA with `data_en` in M1, 0x5 in M2; `data_en`=0 elsewhere.
- SRC (0x21) with X2 `data_i`=CHIP_ID=3 and `rom_cmd`=1, then WRR (0xE2) with X2 `data_i`=0x9 -> `port_o`=0x9 from X3. Repeat with SRC to chip 4 -> `port_o` unchanged.
- After SRC to CHIP_ID, RDR (0xEA) with `port_i`=0x6 -> `data_en`=1, `data_o`=0x6 in X2 only.
- JUN (0x40) followed by a cycle whose byte is 0xE2, with X2 `data_i`=0xF -> byte still driven in M1/M2, `port_o` unchanged, `skip` cleared afterwards. A following real WRR takes effect.
- `halt` held 3 clocks during M1 -> `data_en` stays 1 with the same nibble; the phase resumes to M2 after release. `sync` asserted in A2 -> next phase is A1.
- Reset asserted in M2 -> `data_en`=0 next clock; `port_o`=0; the bus stays undriven until `sync` is seen again.
